// File: rtl/t_to_eta_bin.sv
// Multi-lane converter from track parameter t to a global eta bin index.
// Three-stage pipeline with run-time thresholds and a global valid/ready stall.
module t_to_eta_bin #(
  parameter int T_W      = 16,
  parameter int SECTOR_W = 2,
  parameter int SUBBINS  = 3,
  parameter int ETA_W    = 5,
  parameter int NCH      = 4,
  parameter int TAG_W    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NCH*T_W-1:0]         in_t,
  input  logic [NCH-1:0]             in_mask,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NCH*ETA_W-1:0]       out_eta,
  output logic [NCH-1:0]             out_mask,
  output logic [TAG_W-1:0]           out_tag,
  input  logic                       cfg_we,
  input  logic [2:0]                 cfg_addr,
  input  logic [T_W-SECTOR_W-2:0]    cfg_data
);

  localparam int FRAC_W   = T_W - 1 - SECTOR_W;
  localparam int NTHR     = SUBBINS - 1;
  localparam int REL_W    = $clog2(SUBBINS);
  localparam int THR_STEP = (1 << FRAC_W) / SUBBINS;
  localparam logic [ETA_W-1:0] SUBBINS_E = ETA_W'(SUBBINS);

  // ---------------------------------------------------------------------------
  // Shared sub-bin thresholds
  // ---------------------------------------------------------------------------
  logic [FRAC_W-1:0] thr [NTHR];

  // NOTE: the threshold array is only a handful of flops and must come back to
  // its evenly spaced defaults on reset, so it is reset like any other state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NTHR; k++) begin
        thr[k] <= FRAC_W'((k + 1) * THR_STEP);
      end
    end else if (cfg_we) begin
      // Out-of-range addresses match no entry and are dropped.
      for (int k = 0; k < NTHR; k++) begin
        if (cfg_addr == 3'(k)) thr[k] <= cfg_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-lane decode: sector base and relative sub-bin
  // ---------------------------------------------------------------------------
  logic [NCH-1:0][ETA_W-1:0] base_c;
  logic [NCH-1:0][REL_W-1:0] rel_c;

  // NOTE: every output of this block gets a default before any conditional
  // update, so no path leaves a value held and no latch is inferred.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      // Negative half (sign=1) occupies bins from 0, positive half follows.
      base_c[i] = ETA_W'({~in_t[i*T_W + T_W - 1], in_t[i*T_W + FRAC_W +: SECTOR_W]})
                  * SUBBINS_E;
      rel_c[i]  = '0;
      for (int k = 0; k < NTHR; k++) begin
        if (in_t[i*T_W +: FRAC_W] >= thr[k]) rel_c[i] = rel_c[i] + REL_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline with global stall
  // ---------------------------------------------------------------------------
  logic en;
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  logic                      s1_valid;
  logic [NCH-1:0][ETA_W-1:0] s1_base;
  logic [NCH-1:0][REL_W-1:0] s1_rel;
  logic [NCH-1:0]            s1_mask;
  logic [TAG_W-1:0]          s1_tag;

  logic                      s2_valid;
  logic [NCH-1:0][ETA_W-1:0] s2_eta;
  logic [NCH-1:0]            s2_mask;
  logic [TAG_W-1:0]          s2_tag;

  // NOTE: state registers use non-blocking assignment so every stage samples
  // the previous stage's pre-edge value and the pipeline shifts as one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_base  <= '0;
      s1_rel   <= '0;
      s1_mask  <= '0;
      s1_tag   <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_base <= base_c;
        s1_rel  <= rel_c;
        s1_mask <= in_mask;
        s1_tag  <= in_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_eta   <= '0;
      s2_mask  <= '0;
      s2_tag   <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        for (int i = 0; i < NCH; i++) begin
          s2_eta[i] <= s1_mask[i] ? s1_base[i] + ETA_W'(s1_rel[i]) : '0;
        end
        s2_mask <= s1_mask;
        s2_tag  <= s1_tag;
      end
    end
  end

  // Output register; holds its contents while downstream back-pressures.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_eta   <= '0;
      out_mask  <= '0;
      out_tag   <= '0;
    end else if (en) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_eta  <= s2_eta;
        out_mask <= s2_mask;
        out_tag  <= s2_tag;
      end
    end
  end

endmodule
